fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 17 +
 rtl/inst_fifo.sv | 55 +++++
 rtl/fetch_unit.sv | 78 +++++++
 tb/tb_fetch_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, reset PC and fetch state encoding
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned INST_W = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// rtl/inst_fifo.sv - registered instruction queue with flush and occupancy count
module inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC sequencing and RUN/HALT control feeding the instruction queue
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [XLEN-1:0]        imem_addr,
  input  logic [INST_W-1:0]      imem_data,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INST_W-1:0]      out_inst,
  output logic [XLEN-1:0]        out_pc,
  output logic                   out_fault,
  output logic [$clog2(DEPTH):0] occupancy
);

  fetch_state_t state, next_state;
  logic [XLEN-1:0] pc, next_pc;

  logic                      push;
  logic                      pop;
  logic                      q_full;
  logic                      q_empty;
  logic [XLEN+INST_W-1:0]    q_head;

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN + INST_W)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({pc, imem_data}),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (occupancy)
  );

  assign imem_addr = pc;
  assign out_fault = (state == ST_HALT);
  assign out_valid = (state == ST_RUN) && !q_empty;
  assign pop       = out_valid && out_ready;
  // Head fields are zeroed when invalid so a flushed slot never leaks out.
  assign out_inst  = out_valid ? q_head[INST_W-1:0] : '0;
  assign out_pc    = out_valid ? q_head[XLEN+INST_W-1:INST_W] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      pc    <= RESET_PC;
    end else begin
      state <= next_state;
      pc    <= next_pc;
    end
  end

  always_comb begin
    next_state = state;
    next_pc    = pc;
    push       = 1'b0;
    if (redirect_valid) begin
      next_pc    = redirect_pc;
      next_state = is_aligned(redirect_pc) ? ST_RUN : ST_HALT;
    end else if (state == ST_RUN && (!q_full || pop)) begin
      push    = 1'b1;
      next_pc = pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a queue model
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;
  logic [2:0]  occupancy;

  int errors = 0;
  int checks = 0;

  logic [31:0] mq[$];
  logic [31:0] mpc;
  bit          mhalt;

  fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_fault      (out_fault),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  // Memory word n holds n.
  assign imem_data = {2'b00, imem_addr[31:2]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc   = 32'h0;
    mhalt = 1'b0;
  endtask

  task automatic cycle();
    bit ev;
    bit pop;
    bit room;
    @(negedge clk);
    ev = !mhalt && (mq.size() > 0);
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_fault", 32'(out_fault), 32'(mhalt));
    chk("occupancy", 32'(occupancy), 32'(mq.size()));
    chk("imem_addr", imem_addr, mpc);
    if (ev) begin
      chk("out_pc", out_pc, mq[0]);
      chk("out_inst", out_inst, mq[0] >> 2);
    end
    pop = ev && out_ready;
    if (rst) begin
      model_reset();
    end else if (redirect_valid) begin
      mq.delete();
      mpc   = redirect_pc;
      mhalt = (redirect_pc[1:0] != 2'b00);
    end else begin
      room = mq.size() < DEPTH;
      if (pop) void'(mq.pop_front());
      if (!mhalt && (room || pop)) begin
        mq.push_back(mpc);
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    cycle();
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    cycle();
    redirect_valid = 1'b0;
  endtask

  logic [31:0] wrap_exp [3];

  initial begin
    wrap_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

    #1;
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_occupancy", 32'(occupancy), 32'h0);
    chk("rst_out_fault", 32'(out_fault), 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;

    // Streaming with decode always ready.
    out_ready = 1'b1;
    cycle();
    chk("first_valid", 32'(out_valid), 32'h1);
    chk("first_pc", out_pc, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      cycle();
      chk("stream_pc", out_pc, 32'(i * 4));
    end

    // Backpressure saturates the queue, then drains in order.
    do_reset();
    out_ready = 1'b0;
    repeat (10) cycle();
    chk("stall_occupancy", 32'(occupancy), 32'h4);
    chk("stall_imem_addr", imem_addr, 32'h10);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("drain_valid", 32'(out_valid), 32'h1);
      chk("drain_pc", out_pc, 32'(i * 4));
      cycle();
    end

    // Redirect with occupancy 3 and a coincident handshake.
    do_reset();
    out_ready = 1'b0;
    repeat (3) cycle();
    chk("pre_redir_occ", 32'(occupancy), 32'h3);
    out_ready = 1'b1;
    redirect(32'h100);
    chk("redir_occ", 32'(occupancy), 32'h0);
    chk("redir_valid", 32'(out_valid), 32'h0);
    chk("redir_addr", imem_addr, 32'h100);
    cycle();
    chk("redir_pc0", out_pc, 32'h100);
    cycle();
    chk("redir_pc1", out_pc, 32'h104);

    // Misaligned redirect halts; only an aligned one resumes.
    redirect(32'h102);
    chk("halt_fault", 32'(out_fault), 32'h1);
    chk("halt_valid", 32'(out_valid), 32'h0);
    repeat (4) cycle();
    chk("halt_hold_addr", imem_addr, 32'h102);
    redirect(32'h203);
    chk("halt2_fault", 32'(out_fault), 32'h1);
    chk("halt2_addr", imem_addr, 32'h203);
    redirect(32'h200);
    chk("resume_fault", 32'(out_fault), 32'h0);
    chk("resume_valid", 32'(out_valid), 32'h0);
    cycle();
    chk("resume_pc", out_pc, 32'h200);
    chk("resume_inst", out_inst, 32'h80);

    // PC wraps modulo 2^32.
    redirect(32'hFFFF_FFF8);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("wrap_pc", out_pc, wrap_exp[i]);
    end

    // Asynchronous reset between edges with a full queue.
    out_ready = 1'b0;
    repeat (6) cycle();
    chk("full_occ", 32'(occupancy), 32'h4);
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", 32'(out_valid), 32'h0);
    chk("async_occ", 32'(occupancy), 32'h0);
    chk("async_addr", imem_addr, 32'h0);
    model_reset();
    cycle();
    rst = 1'b0;
    out_ready = 1'b1;
    cycle();
    chk("restart_pc0", out_pc, 32'h0);
    chk("restart_valid", 32'(out_valid), 32'h1);
    cycle();
    chk("restart_pc1", out_pc, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
